// File: rtl/systolic_b_scheduler.sv
// systolic_b_scheduler: sequencer for the B-operand BRAM wrapper.
// Shares the wrapper between host loads and row streaming to the array.
module systolic_b_scheduler #(
  parameter int systolic_size = 2,
  parameter int data_size     = 32,
  parameter int DEPTH         = 128,
  parameter int RA_W          = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [RA_W-1:0] base_addr,
  input  logic [RA_W:0]   num_rows,
  input  logic            array_ready,
  input  logic            abort,
  input  logic            host_req,
  output logic            host_gnt,
  output logic            work,
  output logic            out_in,
  output logic            B_cho,
  output logic [31:0]     memory_address_B,
  output logic            row_valid,
  output logic            busy,
  output logic            done,
  output logic [RA_W:0]   rows_issued
);

  if (DEPTH != (1 << RA_W) || RA_W > 31 ||
      systolic_size < 1 || data_size < 1) begin : g_bad_cfg
    $error("systolic_b_scheduler: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [RA_W:0] ROW_ONE = (RA_W+1)'(1);

  state_t          r_state;
  state_t          w_next;
  logic [RA_W-1:0] r_base;
  logic [RA_W:0]   r_num;
  logic [RA_W:0]   r_rows;
  logic            r_row_valid;
  logic [RA_W:0]   w_rows_inc;
  logic [RA_W-1:0] w_addr;
  logic            w_take;
  logic            w_last;

  assign w_take     = (r_state == S_IDLE) && start && !abort;
  assign w_rows_inc = r_rows + ROW_ONE;
  assign w_last     = (w_rows_inc == r_num);
  assign w_addr     = r_base + r_rows[RA_W-1:0];

  assign rows_issued = r_rows;
  assign row_valid   = r_row_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; abort pulls any active stream back to idle
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take)
            w_next = (num_rows == '0) ? S_DONE : S_STREAM;
        end
        S_STREAM: begin
          if (array_ready && w_last) w_next = S_DRAIN;
        end
        S_DRAIN: w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    host_gnt         = 1'b0;
    B_cho            = 1'b0;
    work             = 1'b0;
    out_in           = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    memory_address_B = 32'd0;
    unique case (r_state)
      S_IDLE: begin
        host_gnt = host_req;
        B_cho    = host_req;
        busy     = 1'b0;
      end
      S_STREAM: begin
        work             = 1'b1;
        out_in           = array_ready;
        memory_address_B = {{(32-RA_W){1'b0}}, w_addr};
      end
      S_DRAIN: work = 1'b1;
      S_DONE:  done = 1'b1;
    endcase
  end

  // Stream parameters, issue counter and read-latency tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_num       <= '0;
      r_rows      <= '0;
      r_row_valid <= 1'b0;
    end else begin
      r_row_valid <= out_in && !abort;
      if (w_take) begin
        r_base <= base_addr;
        r_num  <= num_rows;
        r_rows <= '0;
      end else if (out_in && (r_rows < r_num)) begin
        r_rows <= w_rows_inc;
      end
    end
  end

endmodule

// File: tb/tb_systolic_b_scheduler.sv
// tb_systolic_b_scheduler: table-driven and randomized checks
// against a cycle-schedule reference model.
module tb_systolic_b_scheduler;

  localparam int RA_W  = 7;
  localparam int DEPTH = 128;
  localparam int MAXC  = 600;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [RA_W-1:0] base_addr;
  logic [RA_W:0]   num_rows;
  logic            array_ready;
  logic            abort;
  logic            host_req;
  logic            host_gnt;
  logic            work;
  logic            out_in;
  logic            B_cho;
  logic [31:0]     memory_address_B;
  logic            row_valid;
  logic            busy;
  logic            done;
  logic [RA_W:0]   rows_issued;

  systolic_b_scheduler #(
    .systolic_size(2),
    .data_size(32),
    .DEPTH(DEPTH),
    .RA_W(RA_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .num_rows(num_rows),
    .array_ready(array_ready),
    .abort(abort),
    .host_req(host_req),
    .host_gnt(host_gnt),
    .work(work),
    .out_in(out_in),
    .B_cho(B_cho),
    .memory_address_B(memory_address_B),
    .row_valid(row_valid),
    .busy(busy),
    .done(done),
    .rows_issued(rows_issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rdy[MAXC];
  bit hr[MAXC];

  typedef struct {
    int base;
    int n;
    int lo_a;
    int lo_b;
    int abort_cyc;
    int restart_cyc;
    bit hreq;
    int exp_done;
    int exp_rows;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d got %h exp %h", nm, k, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {25'd0, host_gnt, B_cho, work, out_in, row_valid, busy, done};
  endfunction

  // Cycle of the N-th ready cycle counting from cycle 1 (0 when N = 0)
  function automatic int last_issue(input int n);
    int cnt = 0;
    int l = 0;
    for (int k = 1; k < MAXC; k++) begin
      if (cnt < n && rdy[k]) begin
        cnt++;
        if (cnt == n) l = k;
      end
    end
    return l;
  endfunction

  task automatic run_stream(input int base, input int n, input int a,
                            input int s, output int obs_done,
                            output int obs_rows);
    bit iss[MAXC];
    int l, dc, kend, cnt;
    bit act, wk, dn, rv, hg;
    l   = last_issue(n);
    cnt = 0;
    for (int k = 0; k < MAXC; k++) begin
      iss[k] = 1'b0;
      if (k >= 1 && k <= l && rdy[k] && cnt < n && (a == 0 || k <= a)) begin
        iss[k] = 1'b1;
        cnt++;
      end
    end
    dc   = (n == 0) ? 1 : l + 2;
    kend = (a > 0) ? a + 1 : dc + 1;
    obs_done = 0;
    cnt = 0;
    @(posedge clk); #1;
    start       = 1'b1;
    abort       = 1'b0;
    base_addr   = base[RA_W-1:0];
    num_rows    = n[RA_W:0];
    array_ready = rdy[0];
    host_req    = hr[0];
    @(negedge clk);
    chk("ctl", 0, ctl_vec(), {25'd0, hr[0], hr[0], 5'b00000});
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk); #1;
      start = (k == s);
      if (k == s) begin
        base_addr = RA_W'(base + 40);
        num_rows  = 8'd1;
      end
      array_ready = rdy[k];
      abort       = (k == a);
      host_req    = hr[k];
      @(negedge clk);
      act = (a == 0 || k <= a) && k <= dc;
      wk  = act && n > 0 && k <= l + 1;
      dn  = act && k == dc;
      rv  = iss[k-1] && (k - 1 != a);
      hg  = !act && hr[k];
      chk("ctl", k, ctl_vec(),
          {25'd0, hg, hg, wk, iss[k], rv, act, dn});
      chk("rows", k, 32'(rows_issued), 32'(cnt));
      if (act && n > 0 && k <= l)
        chk("addr", k, memory_address_B, 32'((base + cnt) % DEPTH));
      if (done && obs_done == 0) obs_done = k;
      if (iss[k]) cnt++;
    end
    start    = 1'b0;
    abort    = 1'b0;
    obs_rows = int'(rows_issued);
  endtask

  task automatic fill(input int lo_a, input int lo_b, input bit h);
    for (int k = 0; k < MAXC; k++) begin
      rdy[k] = !(k != 0 && (k == lo_a || k == lo_b));
      hr[k]  = h;
    end
  endtask

  initial begin
    int od, orows, n, base, l, a, s, prev;
    tbl[0]  = '{5,   4,   0, 0, 0, 0, 1'b0, 6,   4};
    tbl[1]  = '{126, 4,   0, 0, 0, 0, 1'b0, 6,   4};
    tbl[2]  = '{0,   6,   2, 3, 0, 0, 1'b0, 10,  6};
    tbl[3]  = '{0,   3,   0, 0, 0, 0, 1'b1, 5,   3};
    tbl[4]  = '{0,   10,  0, 0, 3, 0, 1'b0, 0,   3};
    tbl[5]  = '{9,   0,   0, 0, 0, 0, 1'b1, 1,   0};
    tbl[6]  = '{10,  3,   0, 0, 0, 2, 1'b0, 5,   3};
    tbl[7]  = '{127, 1,   5, 0, 0, 0, 1'b0, 3,   1};
    tbl[8]  = '{3,   128, 0, 0, 0, 0, 1'b0, 130, 128};
    tbl[9]  = '{20,  5,   1, 0, 2, 0, 1'b0, 0,   1};
    tbl[10] = '{0,   2,   0, 0, 3, 0, 1'b0, 0,   2};

    reset = 1'b1; start = 1'b0; abort = 1'b0; host_req = 1'b0;
    array_ready = 1'b0; base_addr = '0; num_rows = '0;
    #12;
    chk("rst_ctl", 0, ctl_vec(), 32'd0);
    chk("rst_addr", 0, memory_address_B, 32'd0);
    chk("rst_rows", 0, 32'(rows_issued), 32'd0);
    host_req = 1'b1;
    #1;
    chk("rst_hgnt", 0, ctl_vec(), 32'h60);
    host_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      fill(tbl[i].lo_a, tbl[i].lo_b, tbl[i].hreq);
      run_stream(tbl[i].base, tbl[i].n, tbl[i].abort_cyc,
                 tbl[i].restart_cyc, od, orows);
      chk($sformatf("tbl%0d_done", i), 0, 32'(od), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_rows", i), 0, 32'(orows), 32'(tbl[i].exp_rows));
    end

    // start together with abort while idle is dropped
    prev = int'(rows_issued);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; num_rows = 8'd5; host_req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abst_ctl", 1, ctl_vec(), 32'd0);
    chk("abst_rows", 1, 32'(rows_issued), 32'(prev));
    @(negedge clk);
    chk("abst_ctl", 2, ctl_vec(), 32'd0);

    // asynchronous reset in the middle of a stream
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; num_rows = 8'd8; array_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("mid_busy", 4, 32'(busy), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ctl", 5, ctl_vec(), 32'h62 & 32'h60);
    chk("mid_rst_rows", 5, 32'(rows_issued), 32'd0);
    chk("mid_rst_addr", 5, memory_address_B, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; host_req = 1'b0;
    @(negedge clk);
    chk("mid_idle", 6, ctl_vec(), 32'd0);

    for (int it = 0; it < 40; it++) begin
      n    = $urandom_range(0, 40);
      base = $urandom_range(0, DEPTH - 1);
      for (int k = 0; k < MAXC; k++) begin
        rdy[k] = (k >= 200) ? 1'b1 : ($urandom % 4 != 0);
        hr[k]  = $urandom % 2;
      end
      l = last_issue(n);
      a = (n > 0 && $urandom % 4 == 0) ? $urandom_range(1, l + 1) : 0;
      s = (n > 0 && $urandom % 3 == 0)
          ? $urandom_range(1, (a > 0) ? a : l + 2) : 0;
      run_stream(base, n, a, s, od, orows);
      chk("rnd_done", it, 32'(od), 32'((a == 0) ? ((n == 0) ? 1 : l + 2) : 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
